// File: rtl/im_loader_pkg.sv
// Shared constants and loader state encodings for the boot-time IM loader.
package im_loader_pkg;

  localparam logic [31:0] IM_BASE       = 32'h0000_3000;
  localparam int unsigned IM_DEPTH_LOG2 = 10;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned LEN_W         = 16;

  typedef enum logic [2:0] {
    LD_LEN_HI = 3'd0,
    LD_LEN_LO = 3'd1,
    LD_DATA   = 3'd2,
    LD_CSUM   = 3'd3,
    LD_DONE   = 3'd4,
    LD_ERR    = 3'd5
  } ld_state_e;

endpackage

// File: rtl/im_loader_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words and pulses word_valid_o
// for one cycle after the 4th byte of each word has been shifted in.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   byte_en_i        a data byte is being accepted this cycle
//   byte_i           the data byte
//   last_byte_c_o    the byte being accepted now completes a word (comb)
//   word_o           shift register contents (full word while word_valid_o)
//   word_valid_o     one-cycle strobe, word_o holds a complete word
module im_loader_byte_packer
  import im_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              last_byte_c_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              word_valid_q, word_valid_d;

  assign last_byte_c_o = (cnt_q == 2'd3);

  // Shift in MSB-first; the 2-bit counter wraps naturally from 3 to 0.
  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    word_valid_d = 1'b0;
    if (byte_en_i) begin
      shift_d      = {shift_q[WORD_W-BYTE_W-1:0], byte_i};
      cnt_d        = cnt_q + 2'd1;
      word_valid_d = (cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q      <= '0;
      cnt_q        <= 2'd0;
      word_valid_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_o       = shift_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction-memory loader. Receives a length-prefixed byte frame,
// writes the packed words to consecutive IM addresses from BASE_ADDR, checks
// an XOR checksum and releases the core on success.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   in_valid     host byte valid
//   in_data      host byte
//   in_ready     loader accepts a byte (low once DONE or ERR)
//   im_we        IM write strobe, one cycle per word
//   im_addr      byte address of the word being written
//   im_wdata     word being written
//   cpu_hold     holds the core in reset until the load succeeds
//   done         load finished with a good checksum (sticky)
//   err          load failed: length too large or bad checksum (sticky)
module im_loader
  import im_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = IM_BASE,
  parameter int unsigned DEPTH_LOG2 = IM_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [31:0]       im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // One extra bit so the index can reach 2**DEPTH_LOG2.
  localparam int unsigned IDX_W = DEPTH_LOG2 + 1;

  ld_state_e         state_q, state_d;
  logic [BYTE_W-1:0] len_hi_q, len_hi_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] xor_q, xor_d;
  logic [31:0]       im_addr_q, im_addr_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept_c;
  logic              data_en_c;
  logic              last_byte_c;
  logic              last_word_c;
  logic [LEN_W-1:0]  len_in_c;
  logic              len_zero_c;
  logic              len_big_c;

  assign accept_c    = in_valid && in_ready_q;
  assign data_en_c   = accept_c && (state_q == LD_DATA);
  assign len_in_c    = {len_hi_q, in_data};
  assign len_zero_c  = (len_in_c == '0);
  assign len_big_c   = (32'(len_in_c) > (32'd1 << DEPTH_LOG2));
  assign last_word_c = ((16'(idx_q) + 16'd1) == len_q);

  im_loader_byte_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .byte_en_i     (data_en_c),
    .byte_i        (in_data),
    .last_byte_c_o (last_byte_c),
    .word_o        (im_wdata),
    .word_valid_o  (im_we)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= LD_LEN_HI;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_LEN_HI: if (accept_c) state_d = LD_LEN_LO;
      LD_LEN_LO: begin
        if (accept_c) begin
          if (len_zero_c)     state_d = LD_CSUM;
          else if (len_big_c) state_d = LD_ERR;
          else                state_d = LD_DATA;
        end
      end
      LD_DATA:   if (data_en_c && last_byte_c && last_word_c) state_d = LD_CSUM;
      LD_CSUM: begin
        if (accept_c) state_d = (in_data == xor_q) ? LD_DONE : LD_ERR;
      end
      LD_DONE:   state_d = LD_DONE;
      LD_ERR:    state_d = LD_ERR;
      default:   state_d = LD_ERR;
    endcase
  end

  // Outputs decoded from the next state so they change on the same edge as the state.
  always_comb begin
    in_ready_d = (state_d != LD_DONE) && (state_d != LD_ERR);
    cpu_hold_d = (state_d != LD_DONE);
    done_d     = (state_d == LD_DONE);
    err_d      = (state_d == LD_ERR);
  end

  // Length capture, word index, running XOR and write address.
  always_comb begin
    len_hi_d  = len_hi_q;
    len_d     = len_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    im_addr_d = im_addr_q;
    if (accept_c) begin
      case (state_q)
        LD_LEN_HI: len_hi_d = in_data;
        LD_LEN_LO: len_d    = len_in_c;
        LD_DATA: begin
          xor_d = xor_q ^ in_data;
          if (last_byte_c) begin
            im_addr_d = BASE_ADDR + 32'({idx_q, 2'b00});
            idx_d     = idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      xor_q      <= '0;
      im_addr_q  <= BASE_ADDR;
      in_ready_q <= 1'b1;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      xor_q      <= xor_d;
      im_addr_q  <= im_addr_d;
      in_ready_q <= in_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign im_addr  = im_addr_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: randomized frames checked against a
// frame-level model (expected writes, checksum and outcome).
module tb_im_loader;

  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam int unsigned MAXW = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  im_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled on the falling edge.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          consec = 0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    if (im_we) begin
      wr_addr_q.push_back(im_addr);
      wr_data_q.push_back(im_wdata);
      wr_cyc_q.push_back(cyc);
      if (prev_we) consec <= consec + 1;
    end
    prev_we <= im_we;
  end

  int tests_run = 0;
  int fails = 0;

  logic [7:0] data_q[$];
  int         acc_cyc_q[$];

  // ---------------- model ----------------
  function automatic logic [7:0] model_csum();
    logic [7:0] x = 8'h00;
    foreach (data_q[i]) x = x ^ data_q[i];
    return x;
  endfunction

  function automatic logic [31:0] model_word(input int k);
    return {data_q[4*k], data_q[4*k+1], data_q[4*k+2], data_q[4*k+3]};
  endfunction

  function automatic logic [31:0] model_addr(input int k);
    return BASE + 32'(4 * k);
  endfunction

  task automatic fill_random(input int n);
    data_q.delete();
    for (int i = 0; i < 4 * n; i++) data_q.push_back(8'($urandom));
  endtask

  // ---------------- drivers ----------------
  // Called and returns on a falling edge; acc reports whether the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap_pct, output bit acc);
    bit rdy;
    int g = 0;
    while (gap_pct > 0 && g < 6 && int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      @(negedge clk);
      g++;
    end
    in_valid = 1'b1;
    in_data  = b;
    rdy      = in_ready;
    @(negedge clk);
    acc = rdy;
    if (rdy) acc_cyc_q.push_back(cyc);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_body(input int n, input int gap_pct);
    bit a;
    send_byte(8'(n >> 8), gap_pct, a);
    send_byte(8'(n), gap_pct, a);
    foreach (data_q[i]) send_byte(data_q[i], gap_pct, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    acc_cyc_q.delete();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests_run++; if (im_we !== 1'b0) begin fails++; $display("FAIL reset_im_we got=%b exp=0", im_we); end
    tests_run++; if (im_addr !== BASE) begin fails++; $display("FAIL reset_im_addr got=%h exp=%h", im_addr, BASE); end
    tests_run++; if (im_wdata !== 32'h0) begin fails++; $display("FAIL reset_im_wdata got=%h exp=0", im_wdata); end
    tests_run++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL reset_cpu_hold got=%b exp=1", cpu_hold); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit a;
    do_reset();
    data_q = '{8'h34, 8'h08, 8'h00, 8'h01, 8'hAC, 8'h09, 8'h00, 8'h00};
    send_body(2, 0);
    tests_run++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin fails++; $display("FAIL basic_pre_csum done=%b hold=%b exp done=0 hold=1", done, cpu_hold); end
    send_byte(model_csum(), 0, a);
    tests_run++; if (done !== 1'b1) begin fails++; $display("FAIL basic_done got=%b exp=1", done); end
    tests_run++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL basic_cpu_hold got=%b exp=0", cpu_hold); end
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL basic_err got=%b exp=0", err); end
    tests_run++; if (wr_addr_q.size() != 2) begin fails++; $display("FAIL basic_wr_count got=%0d exp=2", wr_addr_q.size()); end
    for (int k = 0; k < 2 && k < wr_addr_q.size(); k++) begin
      tests_run++; if (wr_addr_q[k] !== model_addr(k)) begin fails++; $display("FAIL basic_addr%0d got=%h exp=%h", k, wr_addr_q[k], model_addr(k)); end
      tests_run++; if (wr_data_q[k] !== model_word(k)) begin fails++; $display("FAIL basic_data%0d got=%h exp=%h", k, wr_data_q[k], model_word(k)); end
      tests_run++; if (wr_cyc_q[k] != acc_cyc_q[2 + 4*k + 3]) begin fails++; $display("FAIL basic_latency%0d got=%0d exp=%0d", k, wr_cyc_q[k], acc_cyc_q[2 + 4*k + 3]); end
    end
  endtask

  task automatic test_bad_csum();
    bit a;
    do_reset();
    data_q = '{8'h34, 8'h08, 8'h00, 8'h01, 8'hAC, 8'h09, 8'h00, 8'h00};
    send_body(2, 0);
    send_byte(model_csum() ^ 8'h01, 0, a);
    tests_run++; if (err !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL badcs_flags err=%b done=%b exp err=1 done=0", err, done); end
    tests_run++; if (cpu_hold !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL badcs_hold_ready hold=%b rdy=%b exp hold=1 rdy=0", cpu_hold, in_ready); end
    tests_run++; if (wr_addr_q.size() != 2) begin fails++; $display("FAIL badcs_wr_count got=%0d exp=2", wr_addr_q.size()); end
    send_byte(8'h55, 0, a);
    tests_run++; if (a !== 1'b0 || err !== 1'b1 || wr_addr_q.size() != 2) begin fails++; $display("FAIL badcs_terminal acc=%b err=%b writes=%0d exp acc=0 err=1 writes=2", a, err, wr_addr_q.size()); end
  endtask

  task automatic test_zero_len();
    bit a;
    do_reset();
    data_q.delete();
    send_body(0, 0);
    send_byte(8'h00, 0, a);
    tests_run++; if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL zero_done done=%b err=%b exp done=1 err=0", done, err); end
    tests_run++; if (wr_addr_q.size() != 0) begin fails++; $display("FAIL zero_writes got=%0d exp=0", wr_addr_q.size()); end
    do_reset();
    send_body(0, 0);
    send_byte(8'h01, 0, a);
    tests_run++; if (err !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL zero_badcs err=%b done=%b exp err=1 done=0", err, done); end
  endtask

  task automatic test_too_long();
    int lens[2];
    bit a;
    lens[0] = 32'h0401;
    lens[1] = int'($urandom_range(16'hFFFF, 16'h0402));
    for (int i = 0; i < 2; i++) begin
      do_reset();
      data_q.delete();
      send_body(lens[i], 0);
      tests_run++; if (err !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL toolong_%0h err=%b rdy=%b exp err=1 rdy=0", lens[i], err, in_ready); end
      send_byte(8'hA5, 0, a);
      tests_run++; if (a !== 1'b0 || wr_addr_q.size() != 0 || done !== 1'b0) begin fails++; $display("FAIL toolong_after_%0h acc=%b writes=%0d done=%b exp 0 0 0", lens[i], a, wr_addr_q.size(), done); end
    end
  endtask

  task automatic test_full_depth();
    bit a;
    int base_consec;
    do_reset();
    base_consec = consec;
    fill_random(MAXW);
    send_body(MAXW, 0);
    send_byte(model_csum(), 0, a);
    tests_run++; if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL full_done done=%b err=%b exp done=1 err=0", done, err); end
    tests_run++; if (wr_addr_q.size() != MAXW) begin fails++; $display("FAIL full_wr_count got=%0d exp=%0d", wr_addr_q.size(), MAXW); end
    if (wr_addr_q.size() == MAXW) begin
      tests_run++; if (wr_addr_q[MAXW-1] !== 32'h0000_3FFC) begin fails++; $display("FAIL full_last_addr got=%h exp=00003ffc", wr_addr_q[MAXW-1]); end
      for (int k = 0; k < MAXW; k++) begin
        tests_run++;
        if (wr_addr_q[k] !== model_addr(k) || wr_data_q[k] !== model_word(k)) begin
          fails++;
          $display("FAIL full_word%0d got=%h@%h exp=%h@%h", k, wr_data_q[k], wr_addr_q[k], model_word(k), model_addr(k));
        end
      end
    end
    tests_run++; if (consec != base_consec) begin fails++; $display("FAIL full_consec got=%0d exp=0", consec - base_consec); end
  endtask

  task automatic test_gaps();
    bit a;
    logic [31:0] ref_addr[$];
    logic [31:0] ref_data[$];
    int base_consec;
    fill_random(3);
    do_reset();
    send_body(3, 0);
    send_byte(model_csum(), 0, a);
    ref_addr = wr_addr_q;
    ref_data = wr_data_q;
    do_reset();
    base_consec = consec;
    send_body(3, 40);
    send_byte(model_csum(), 40, a);
    tests_run++; if (wr_addr_q.size() != 3 || ref_addr.size() != 3) begin fails++; $display("FAIL gaps_wr_count got=%0d ref=%0d exp=3", wr_addr_q.size(), ref_addr.size()); end
    for (int k = 0; k < 3 && k < wr_addr_q.size() && k < ref_addr.size(); k++) begin
      tests_run++;
      if (wr_addr_q[k] !== ref_addr[k] || wr_data_q[k] !== ref_data[k] ||
          wr_addr_q[k] !== model_addr(k) || wr_data_q[k] !== model_word(k)) begin
        fails++;
        $display("FAIL gaps_word%0d got=%h@%h ref=%h@%h exp=%h@%h", k, wr_data_q[k], wr_addr_q[k],
                 ref_data[k], ref_addr[k], model_word(k), model_addr(k));
      end
    end
    tests_run++; if (consec != base_consec) begin fails++; $display("FAIL gaps_consec got=%0d exp=0", consec - base_consec); end
    tests_run++; if (done !== 1'b1) begin fails++; $display("FAIL gaps_done got=%b exp=1", done); end
  endtask

  task automatic test_reset_mid();
    bit a;
    do_reset();
    send_byte(8'h00, 0, a);
    send_byte(8'h01, 0, a);
    send_byte(8'hDE, 0, a);
    send_byte(8'hAD, 0, a);
    send_byte(8'hBE, 0, a);
    in_valid = 1'b1;
    in_data  = 8'hEF;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (im_we !== 1'b0) begin fails++; $display("FAIL rstmid_im_we got=%b exp=0", im_we); end
    tests_run++; if (in_ready !== 1'b1 || im_addr !== BASE) begin fails++; $display("FAIL rstmid_state rdy=%b addr=%h exp rdy=1 addr=%h", in_ready, im_addr, BASE); end
    @(negedge clk);
    tests_run++; if (wr_addr_q.size() != 0) begin fails++; $display("FAIL rstmid_writes got=%0d exp=0", wr_addr_q.size()); end
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    acc_cyc_q.delete();
    reset = 1'b0;
    data_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_body(1, 0);
    send_byte(model_csum(), 0, a);
    tests_run++; if (wr_addr_q.size() != 1) begin fails++; $display("FAIL rstmid_new_count got=%0d exp=1", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 1) begin
      tests_run++; if (wr_data_q[0] !== 32'hDEADBEEF || wr_addr_q[0] !== BASE) begin fails++; $display("FAIL rstmid_new_word got=%h@%h exp=deadbeef@%h", wr_data_q[0], wr_addr_q[0], BASE); end
    end
    tests_run++; if (done !== 1'b1) begin fails++; $display("FAIL rstmid_done got=%b exp=1", done); end
  endtask

  task automatic test_random();
    bit a;
    int n, gap, base_consec;
    bit bad;
    logic [7:0] cs;
    for (int it = 0; it < 6; it++) begin
      n   = int'($urandom_range(8, 1));
      gap = int'($urandom_range(50, 0));
      bad = 1'($urandom_range(1, 0));
      fill_random(n);
      do_reset();
      base_consec = consec;
      send_body(n, gap);
      cs = bad ? (model_csum() ^ 8'(int'($urandom_range(255, 1)))) : model_csum();
      send_byte(cs, gap, a);
      tests_run++; if (done !== !bad || err !== bad || cpu_hold !== bad) begin fails++; $display("FAIL rand%0d_outcome done=%b err=%b hold=%b exp done=%b err=%b", it, done, err, cpu_hold, !bad, bad); end
      tests_run++; if (wr_addr_q.size() != n) begin fails++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, wr_addr_q.size(), n); end
      for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
        tests_run++;
        if (wr_addr_q[k] !== model_addr(k) || wr_data_q[k] !== model_word(k)) begin
          fails++;
          $display("FAIL rand%0d_word%0d got=%h@%h exp=%h@%h", it, k, wr_data_q[k], wr_addr_q[k], model_word(k), model_addr(k));
        end
      end
      tests_run++; if (consec != base_consec) begin fails++; $display("FAIL rand%0d_consec got=%0d exp=0", it, consec - base_consec); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_zero_len();
    test_too_long();
    test_full_depth();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
